// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - instruction/data memory handshake bundle for core_sequencer
interface core_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             dmem_req;
  logic             dmem_ack;

  // Sequencer side: issues requests, consumes acknowledges and fetch data.
  modport master (
    output imem_req,
    output imem_addr,
    output dmem_req,
    input  imem_ack,
    input  imem_rdata,
    input  dmem_ack
  );

  // Memory side: observes requests, returns acknowledges and fetch data.
  modport slave (
    input  imem_req,
    input  imem_addr,
    input  dmem_req,
    output imem_ack,
    output imem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback control sequencer
module core_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  core_sequencer_if.master    bus,
  output logic [WIDTH-1:0]    inst,
  input  logic [8:0]          instr_type,
  input  logic                rde,
  input  logic                taken,
  input  logic [WIDTH-1:0]    target,
  output logic                rf_we,
  output logic                retired,
  output logic [31:0]         retire_cnt,
  output logic                trap,
  output logic [2:0]          state
);

  // Decoder class codes that steer the sequencer.
  localparam logic [8:0] IT_ILLEGAL   = 9'h07F;
  localparam logic [8:0] IT_LOAD      = 9'd35;
  localparam logic [8:0] IT_JAL       = 9'd8;
  localparam logic [8:0] IT_JALR      = 9'd9;
  localparam logic [8:0] IT_BRANCH_LO = 9'd10;
  localparam logic [8:0] IT_BRANCH_HI = 9'd15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] next_pc;
  logic [31:0]      retire_cnt_q;
  logic             trap_q;

  logic             is_jump;
  logic             is_branch;
  logic             redirect;
  logic             misaligned;

  assign is_jump    = (instr_type == IT_JAL) || (instr_type == IT_JALR);
  assign is_branch  = (instr_type >= IT_BRANCH_LO) && (instr_type <= IT_BRANCH_HI);
  assign redirect   = is_jump || (is_branch && taken);
  assign misaligned = redirect && (target[1:0] != 2'b00);

  // Requests and strobes decode from the registered state only, so an ack
  // never feeds straight through to a request in the same cycle.
  assign bus.imem_req  = (state_q == FETCH);
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = (state_q == MEM);
  assign rf_we         = (state_q == WB) && rde;
  assign retired       = (state_q == WB);
  assign retire_cnt    = retire_cnt_q;
  assign trap          = trap_q;
  assign state         = state_q;

  // State register; reset forces IDLE at once, which also drops every request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; run only gates the start of a new instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (bus.imem_ack) state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if ((instr_type == IT_ILLEGAL) || misaligned) begin
          state_d = TRAP;
        end else if (instr_type == IT_LOAD) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM:    if (bus.dmem_ack) state_d = WB;
      WB:     state_d = run ? FETCH : IDLE;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Instruction latch: captured only on the edge that completes a fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst <= '0;
    end else if ((state_q == FETCH) && bus.imem_ack) begin
      inst <= bus.imem_rdata;
    end
  end

  // Next PC is resolved in EXEC and committed in WB, so a trap leaves pc
  // pointing at the faulting instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      next_pc <= RESET_PC;
    end else begin
      if (state_q == EXEC) begin
        next_pc <= redirect ? target : (pc + WIDTH'(4));
      end
      if (state_q == WB) begin
        pc <= next_pc;
      end
    end
  end

  // Retired-instruction counter, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= 32'd0;
    end else if (state_q == WB) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  // Sticky trap flag, raised together with entry into TRAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_q <= 1'b0;
    end else if (state_d == TRAP) begin
      trap_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] inst;
  logic [8:0]  instr_type;
  logic        rde;
  logic        taken;
  logic [31:0] target;
  logic        rf_we;
  logic        retired;
  logic [31:0] retire_cnt;
  logic        trap;
  logic [2:0]  state;

  int n_checks;
  int n_pass;
  int cyc;
  int cyc_start;
  int dreq_cycles;
  int bad_strobes;

  core_sequencer_if #(.WIDTH(32)) bus ();

  core_sequencer #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .bus        (bus),
    .inst       (inst),
    .instr_type (instr_type),
    .rde        (rde),
    .taken      (taken),
    .target     (target),
    .rf_we      (rf_we),
    .retired    (retired),
    .retire_cnt (retire_cnt),
    .trap       (trap),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    reset    = 1'b0;
    run      = 1'b0;
    instr_type = 9'd0;
    rde      = 1'b0;
    taken    = 1'b0;
    target   = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.dmem_ack   = 1'b0;

    // Reset values
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_retire_cnt", retire_cnt, 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);

    // Release with run=0: must hold IDLE
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);

    // ADDI, immediate ack
    run = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    instr_type = 9'd16;
    rde = 1'b1;
    tick();
    check("addi_fetch_state", 32'(state), 32'd1);
    check("addi_imem_req", 32'(bus.imem_req), 32'd1);
    check("addi_imem_addr", bus.imem_addr, 32'd0);
    tick();
    check("addi_decode_state", 32'(state), 32'd2);
    check("addi_inst", inst, 32'h0050_0093);
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("addi_exec_state", 32'(state), 32'd3);
    check("inst_ignores_ack", inst, 32'h0050_0093);
    check("addi_exec_rf_we", 32'(rf_we), 32'd0);
    tick();
    check("addi_wb_state", 32'(state), 32'd5);
    check("addi_rf_we", 32'(rf_we), 32'd1);
    check("addi_retired", 32'(retired), 32'd1);
    tick();
    check("addi_next_fetch", 32'(state), 32'd1);
    check("addi_pc", bus.imem_addr, 32'd4);
    check("addi_retire_cnt", retire_cnt, 32'd1);
    check("addi_rf_we_once", 32'(rf_we), 32'd0);

    // LOAD with dmem_ack delayed 3 cycles
    cyc_start = cyc;
    bus.imem_rdata = 32'h0000_2083;
    instr_type = 9'd35;
    rde = 1'b1;
    tick();
    tick();
    check("load_exec_state", 32'(state), 32'd3);
    dreq_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.dmem_req) dreq_cycles++;
      if (i == 0) check("load_mem_state", 32'(state), 32'd4);
      if (i == 3) bus.dmem_ack = 1'b1;
    end
    check("load_dmem_req_cycles", 32'(dreq_cycles), 32'd4);
    tick();
    check("load_wb_state", 32'(state), 32'd5);
    check("load_rf_we", 32'(rf_we), 32'd1);
    check("load_dmem_req_low", 32'(bus.dmem_req), 32'd0);
    check("load_latency", 32'(cyc - cyc_start + 1), 32'd8);
    bus.dmem_ack = 1'b0;
    tick();
    check("load_pc", bus.imem_addr, 32'd8);
    check("load_retire_cnt", retire_cnt, 32'd2);

    // BEQ taken to 0x40
    instr_type = 9'd10;
    taken = 1'b1;
    target = 32'h0000_0040;
    rde = 1'b0;
    tick();
    tick();
    tick();
    check("beq_wb_rf_we", 32'(rf_we), 32'd0);
    check("beq_wb_retired", 32'(retired), 32'd1);
    tick();
    check("beq_target", bus.imem_addr, 32'h0000_0040);

    // BNE not taken
    instr_type = 9'd11;
    taken = 1'b0;
    target = 32'h0000_0080;
    tick();
    tick();
    tick();
    tick();
    check("bne_fallthrough", bus.imem_addr, 32'h0000_0044);
    check("bne_retire_cnt", retire_cnt, 32'd4);

    // JAL to the top word, then ADDI there wraps to 0; run dropped in DECODE
    instr_type = 9'd8;
    target = 32'hFFFF_FFFC;
    rde = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("jal_top_pc", bus.imem_addr, 32'hFFFF_FFFC);
    instr_type = 9'd16;
    tick();
    check("wrap_decode_state", 32'(state), 32'd2);
    run = 1'b0;
    tick();
    check("wrap_exec_state", 32'(state), 32'd3);
    tick();
    check("wrap_retired", 32'(retired), 32'd1);
    tick();
    check("rundrop_idle", 32'(state), 32'd0);
    check("rundrop_imem_req", 32'(bus.imem_req), 32'd0);
    check("wrap_pc", bus.imem_addr, 32'd0);
    check("wrap_retire_cnt", retire_cnt, 32'd6);
    tick();
    check("rundrop_idle_hold", 32'(state), 32'd0);
    run = 1'b1;
    tick();
    check("restart_fetch", 32'(state), 32'd1);
    check("restart_addr", bus.imem_addr, 32'd0);

    // JAL to misaligned 0x42 traps with pc frozen
    instr_type = 9'd8;
    target = 32'h0000_0042;
    tick();
    tick();
    tick();
    check("jal_mis_state", 32'(state), 32'd6);
    check("jal_mis_trap", 32'(trap), 32'd1);
    check("jal_mis_retired", 32'(retired), 32'd0);
    check("jal_mis_pc", bus.imem_addr, 32'd0);
    tick();
    tick();
    check("trap_stays", 32'(state), 32'd6);
    check("trap_no_imem_req", 32'(bus.imem_req), 32'd0);
    check("trap_retire_cnt", retire_cnt, 32'd6);
    reset = 1'b0;
    #1;
    check("trap_rst_clear", 32'(trap), 32'd0);
    check("trap_rst_state", 32'(state), 32'd0);
    check("trap_rst_cnt", retire_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Illegal instruction class traps without writeback
    instr_type = 9'h07F;
    rde = 1'b1;
    tick();
    check("ill_fetch_addr", bus.imem_addr, 32'd0);
    tick();
    tick();
    bad_strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rf_we || retired || bus.imem_req || bus.dmem_req) bad_strobes++;
    end
    check("ill_state", 32'(state), 32'd6);
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_no_strobes", 32'(bad_strobes), 32'd0);
    check("ill_retire_cnt", retire_cnt, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ill_rst_trap", 32'(trap), 32'd0);
    check("ill_rst_state", 32'(state), 32'd0);
    reset = 1'b1;

    // Reset asserted mid-MEM drops dmem_req asynchronously
    instr_type = 9'd35;
    bus.dmem_ack = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("mem_req_before_rst", 32'(bus.dmem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_imem_req", 32'(bus.imem_req), 32'd0);
    check("async_rf_we", 32'(rf_we), 32'd0);
    check("async_retired", 32'(retired), 32'd0);
    check("async_inst", inst, 32'd0);
    check("async_imem_addr", bus.imem_addr, 32'd0);
    check("async_retire_cnt", retire_cnt, 32'd0);
    check("async_trap", 32'(trap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data/address width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; it is asynchronous and active-low (0 = in reset).
REQ-005 The block SHALL have port run, input, 1, meaning permission to start or continue fetching.
REQ-006 The block SHALL have port imem_req, output, 1, meaning instruction fetch request.
REQ-007 The block SHALL have port imem_addr, output, WIDTH, meaning the current PC.
REQ-008 The block SHALL have port imem_ack, input, 1, meaning fetch data valid this cycle.
REQ-009 The block SHALL have port imem_rdata, input, WIDTH, meaning the fetched word.
REQ-010 The block SHALL have port inst, output, WIDTH, meaning the latched instruction that drives the decoder.
REQ-011 The block SHALL have port instr_type, input, 9, meaning the decoder class code (registered, 1-cycle latency).
REQ-012 The block SHALL have port rde, input, 1, meaning the decoder's destination-write valid.
REQ-013 The block SHALL have port taken, input, 1, meaning the branch condition true from the datapath.
REQ-014 The block SHALL have port target, input, WIDTH, meaning the branch/jump target from the datapath.
REQ-015 The block SHALL have port dmem_req, output, 1, meaning load request.
REQ-016 The block SHALL have port dmem_ack, input, 1, meaning load data valid.
REQ-017 The block SHALL have port rf_we, output, 1, meaning the register-file write strobe.
REQ-018 The block SHALL have port retired, output, 1, meaning a 1-cycle pulse per completed instruction.
REQ-019 The block SHALL have port retire_cnt, output, 32, meaning the count of retired instructions.
REQ-020 The block SHALL have port trap, output, 1, meaning sticky illegal/misaligned indication.
REQ-021 The block SHALL have port state, output, 3, meaning the FSM state encoding.

Function
REQ-022 The FSM states SHALL be encoded as IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; 7 is unused and SHALL return to IDLE.
REQ-023 In IDLE, run=1 SHALL move the FSM to FETCH on the next edge; run=0 SHALL hold IDLE.
REQ-024 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; the state SHALL hold until imem_ack=1, then inst<=imem_rdata and go to DECODE; ack in the first FETCH cycle is legal.
REQ-025 imem_ack outside FETCH SHALL be ignored; inst SHALL change only on the FETCH+ack edge.
REQ-026 DECODE SHALL last exactly 1 cycle, so that instr_type and rde are valid in EXEC.
REQ-027 In EXEC, instr_type=9'h07F SHALL go to TRAP; instr_type=35 (LOAD) SHALL go to MEM; any other value SHALL go to WB; EXEC SHALL last exactly 1 cycle.
REQ-028 Store encodings decode to 9'h07F and SHALL therefore trap.
REQ-029 In EXEC, a redirect SHALL be taken when instr_type is 8 (JAL) or 9 (JALR), or when instr_type is 10..15 (branch) with taken=1; a redirect with target[1:0]!=0 SHALL go to TRAP instead of WB/MEM.
REQ-030 The next PC SHALL be captured in EXEC as target on redirect, else pc+4 modulo 2^WIDTH (0xFFFF_FFFC+4 wraps to 0).
REQ-031 In MEM, dmem_req SHALL be 1 until dmem_ack=1, then the FSM SHALL go to WB.
REQ-032 In WB, rf_we SHALL equal rde (1 cycle only), retired SHALL be 1, pc SHALL be loaded with the captured next PC, and retire_cnt SHALL increment, wrapping 0xFFFF_FFFF to 0.
REQ-033 From WB, the FSM SHALL go to FETCH if run=1, else to IDLE; run=0 in any other state SHALL NOT abort the instruction in flight.
REQ-034 TRAP SHALL set trap=1 and SHALL be left only by reset; in TRAP all requests and strobes SHALL be 0 and pc SHALL be frozen at the faulting instruction.
REQ-035 imem_req, dmem_req, rf_we and retired SHALL be pure decodes of state (plus rde), with no combinational path from an ack input.
REQ-036 Minimum latency SHALL be 4 cycles per non-load instruction (FETCH, DECODE, EXEC, WB) and 5 cycles per load.

Reset
REQ-037 While reset=0, the block SHALL hold state=IDLE, pc=RESET_PC, inst=0, retire_cnt=0, trap=0, and all request/strobe outputs=0.
REQ-038 Assertion of reset mid-operation, including in FETCH or MEM with a request outstanding, SHALL drop requests immediately and asynchronously.
REQ-039 On release, the block SHALL leave IDLE no earlier than the first edge with reset=1 and run=1.

Verification
REQ-040 The bench SHALL cover: run=1, imem_ack immediate, ADDI, instr_type=16, rde=1 -> imem_req at cycle 1, rf_we and retired in cycle 4, pc 0->4, retire_cnt=1.
REQ-041 The bench SHALL cover: LOAD with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, rf_we 1 cycle after ack, total 8 cycles.
REQ-042 The bench SHALL cover: BEQ with taken=1 and target=0x40 -> next imem_addr=0x40; BNE with taken=0 -> pc+4; JAL with target=0x42 -> trap=1, pc frozen.
REQ-043 The bench SHALL cover: instr_type=9'h07F -> TRAP, trap=1, no rf_we or retired; trap cleared only by reset=0.
REQ-044 The bench SHALL cover: pc=0xFFFF_FFFC with a non-branch -> next fetch at 0; run dropped in DECODE -> instruction retires, then IDLE.
REQ-045 The bench SHALL cover: reset=0 asserted during MEM with dmem_req=1 -> dmem_req=0 the same cycle, with all outputs at their REQ-037 values.
